// File: rtl/axi_demux_pkg.sv
// axi_demux_pkg: shared types, response codes and helpers for the AXI address demux
package axi_demux_pkg;
  typedef struct packed {
    logic [63:0] base;
    logic [63:0] mask;
    logic [3:0]  port;
  } rule_t;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;
  // index width able to address ports 0..n, where n is the internal error port
  function automatic int port_idx_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/axi_demux_err_resp.sv
// axi_demux_err_resp: DECERR slave for unmapped addresses, one write and one read at a time
module axi_demux_err_resp
  import axi_demux_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ID_W-1:0]   aw_id,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic              w_last,
  input  logic              w_valid,
  output logic              w_ready,
  output logic [ID_W-1:0]   b_id,
  output logic [1:0]        b_resp,
  output logic              b_valid,
  input  logic              b_ready,
  input  logic [ID_W-1:0]   ar_id,
  input  logic [7:0]        ar_len,
  input  logic              ar_valid,
  output logic              ar_ready,
  output logic [ID_W-1:0]   r_id,
  output logic [DATA_W-1:0] r_data,
  output logic [1:0]        r_resp,
  output logic              r_last,
  output logic              r_valid,
  input  logic              r_ready
);
  wr_state_e       wr_state_q, wr_state_d;
  rd_state_e       rd_state_q, rd_state_d;
  logic [ID_W-1:0] aw_id_q, aw_id_d, ar_id_q, ar_id_d;
  logic [7:0]      beats_q, beats_d;

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      aw_id_q    <= '0;
      ar_id_q    <= '0;
      beats_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_id_q    <= aw_id_d;
      ar_id_q    <= ar_id_d;
      beats_q    <= beats_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    aw_id_d    = aw_id_q;
    rd_state_d = rd_state_q;
    ar_id_d    = ar_id_q;
    beats_d    = beats_q;
    case (wr_state_q)
      WR_IDLE: if (aw_valid) begin
        wr_state_d = WR_DATA;
        aw_id_d    = aw_id;
      end
      WR_DATA: if (w_valid && w_last) wr_state_d = WR_RESP;
      WR_RESP: if (b_ready) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
    if (rd_state_q == RD_IDLE && ar_valid) begin
      rd_state_d = RD_DATA;
      ar_id_d    = ar_id;
      beats_d    = ar_len;
    end else if (rd_state_q == RD_DATA && r_ready) begin
      rd_state_d = (beats_q == '0) ? RD_IDLE : RD_DATA;
      beats_d    = (beats_q == '0) ? beats_q : beats_q - 8'd1;
    end
  end

  always_comb begin
    aw_ready = wr_state_q == WR_IDLE;
    w_ready  = wr_state_q == WR_DATA;
    b_valid  = wr_state_q == WR_RESP;
    b_id     = aw_id_q;
    b_resp   = RESP_DECERR;
    ar_ready = rd_state_q == RD_IDLE;
    r_valid  = rd_state_q == RD_DATA;
    r_last   = (rd_state_q == RD_DATA) && (beats_q == '0);
    r_id     = ar_id_q;
    r_data   = '0;
    r_resp   = RESP_DECERR;
  end
endmodule

// File: rtl/axi_addr_demux.sv
// axi_addr_demux: routes one AXI slave port to NUM_PORTS masters by address rules,
// with a DECERR responder behind unmapped addresses
module axi_addr_demux
  import axi_demux_pkg::*;
#(
  parameter int NUM_PORTS = 8,
  parameter int NUM_RULES = 8,
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_TRANS = 2,
  parameter rule_t [NUM_RULES-1:0] RULES = '0
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic [ID_W-1:0]                     s_aw_id,
  input  logic [ADDR_W-1:0]                   s_aw_addr,
  input  logic [7:0]                          s_aw_len,
  input  logic [2:0]                          s_aw_size,
  input  logic [1:0]                          s_aw_burst,
  input  logic                                s_aw_valid,
  output logic                                s_aw_ready,
  input  logic [DATA_W-1:0]                   s_w_data,
  input  logic [DATA_W/8-1:0]                 s_w_strb,
  input  logic                                s_w_last,
  input  logic                                s_w_valid,
  output logic                                s_w_ready,
  output logic [ID_W-1:0]                     s_b_id,
  output logic [1:0]                          s_b_resp,
  output logic                                s_b_valid,
  input  logic                                s_b_ready,
  input  logic [ID_W-1:0]                     s_ar_id,
  input  logic [ADDR_W-1:0]                   s_ar_addr,
  input  logic [7:0]                          s_ar_len,
  input  logic [2:0]                          s_ar_size,
  input  logic [1:0]                          s_ar_burst,
  input  logic                                s_ar_valid,
  output logic                                s_ar_ready,
  output logic [ID_W-1:0]                     s_r_id,
  output logic [DATA_W-1:0]                   s_r_data,
  output logic [1:0]                          s_r_resp,
  output logic                                s_r_last,
  output logic                                s_r_valid,
  input  logic                                s_r_ready,
  output logic [ID_W-1:0]                     m_aw_id,
  output logic [ADDR_W-1:0]                   m_aw_addr,
  output logic [7:0]                          m_aw_len,
  output logic [2:0]                          m_aw_size,
  output logic [1:0]                          m_aw_burst,
  output logic [NUM_PORTS-1:0]                m_aw_valid,
  input  logic [NUM_PORTS-1:0]                m_aw_ready,
  output logic [DATA_W-1:0]                   m_w_data,
  output logic [DATA_W/8-1:0]                 m_w_strb,
  output logic                                m_w_last,
  output logic [NUM_PORTS-1:0]                m_w_valid,
  input  logic [NUM_PORTS-1:0]                m_w_ready,
  input  logic [NUM_PORTS-1:0][ID_W-1:0]      m_b_id,
  input  logic [NUM_PORTS-1:0][1:0]           m_b_resp,
  input  logic [NUM_PORTS-1:0]                m_b_valid,
  output logic [NUM_PORTS-1:0]                m_b_ready,
  output logic [ID_W-1:0]                     m_ar_id,
  output logic [ADDR_W-1:0]                   m_ar_addr,
  output logic [7:0]                          m_ar_len,
  output logic [2:0]                          m_ar_size,
  output logic [1:0]                          m_ar_burst,
  output logic [NUM_PORTS-1:0]                m_ar_valid,
  input  logic [NUM_PORTS-1:0]                m_ar_ready,
  input  logic [NUM_PORTS-1:0][ID_W-1:0]      m_r_id,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]    m_r_data,
  input  logic [NUM_PORTS-1:0][1:0]           m_r_resp,
  input  logic [NUM_PORTS-1:0]                m_r_last,
  input  logic [NUM_PORTS-1:0]                m_r_valid,
  output logic [NUM_PORTS-1:0]                m_r_ready
);
  localparam int PW  = port_idx_w(NUM_PORTS);
  localparam int CW  = $clog2(MAX_TRANS + 1);
  localparam int IW  = (MAX_TRANS > 1) ? $clog2(MAX_TRANS) : 1;
  localparam int NP1 = NUM_PORTS + 1;

  logic [PW-1:0]                 aw_sel, ar_sel, w_port;
  logic                          aw_allow, ar_allow, aw_hs, ar_hs, b_hs, r_done, w_pop;
  logic                          wf_empty, wf_full;
  logic [NUM_PORTS:0]            aw_rdy_all, w_rdy_all, b_vld_all, ar_rdy_all, r_vld_all, r_last_all;
  logic [NUM_PORTS:0][ID_W-1:0]  b_id_all, r_id_all;
  logic [NUM_PORTS:0][1:0]       b_resp_all, r_resp_all;
  logic [NUM_PORTS:0][DATA_W-1:0] r_data_all;
  logic                          err_aw_valid, err_aw_ready, err_w_valid, err_w_ready;
  logic [ID_W-1:0]               err_b_id, err_r_id;
  logic [1:0]                    err_b_resp, err_r_resp;
  logic                          err_b_valid, err_b_ready, err_ar_valid, err_ar_ready;
  logic [DATA_W-1:0]             err_r_data;
  logic                          err_r_last, err_r_valid, err_r_ready;
  logic [CW-1:0]                 wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, wf_cnt_q, wf_cnt_d;
  logic [PW-1:0]                 wr_lock_q, wr_lock_d, rd_lock_q, rd_lock_d;
  logic [MAX_TRANS-1:0][PW-1:0]  wf_mem_q, wf_mem_d;
  logic [IW-1:0]                 wf_wr_q, wf_wr_d, wf_rd_q, wf_rd_d;

  // lowest-index matching rule wins; no match selects the error port
  function automatic logic [PW-1:0] decode(input logic [ADDR_W-1:0] a);
    decode = PW'(NUM_PORTS);
    for (int i = NUM_RULES - 1; i >= 0; i--)
      if ((a & ADDR_W'(RULES[i].mask)) == ADDR_W'(RULES[i].base)) decode = PW'(RULES[i].port);
  endfunction

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
    return (p == IW'(MAX_TRANS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign m_aw_id    = s_aw_id;
  assign m_aw_addr  = s_aw_addr;
  assign m_aw_len   = s_aw_len;
  assign m_aw_size  = s_aw_size;
  assign m_aw_burst = s_aw_burst;
  assign m_w_data   = s_w_data;
  assign m_w_strb   = s_w_strb;
  assign m_w_last   = s_w_last;
  assign m_ar_id    = s_ar_id;
  assign m_ar_addr  = s_ar_addr;
  assign m_ar_len   = s_ar_len;
  assign m_ar_size  = s_ar_size;
  assign m_ar_burst = s_ar_burst;
  assign aw_rdy_all = {err_aw_ready, m_aw_ready};
  assign w_rdy_all  = {err_w_ready, m_w_ready};
  assign b_vld_all  = {err_b_valid, m_b_valid};
  assign b_id_all   = {err_b_id, m_b_id};
  assign b_resp_all = {err_b_resp, m_b_resp};
  assign ar_rdy_all = {err_ar_ready, m_ar_ready};
  assign r_vld_all  = {err_r_valid, m_r_valid};
  assign r_last_all = {err_r_last, m_r_last};
  assign r_id_all   = {err_r_id, m_r_id};
  assign r_data_all = {err_r_data, m_r_data};
  assign r_resp_all = {err_r_resp, m_r_resp};
  assign aw_sel     = decode(s_aw_addr);
  assign ar_sel     = decode(s_ar_addr);
  assign wf_empty   = wf_cnt_q == '0;
  assign wf_full    = wf_cnt_q == CW'(MAX_TRANS);
  assign w_port     = wf_mem_q[wf_rd_q];

  always_comb begin
    aw_allow   = (wr_cnt_q < CW'(MAX_TRANS)) && (wr_cnt_q == '0 || aw_sel == wr_lock_q) && !wf_full;
    ar_allow   = (rd_cnt_q < CW'(MAX_TRANS)) && (rd_cnt_q == '0 || ar_sel == rd_lock_q);
    s_aw_ready = aw_rdy_all[aw_sel] && aw_allow;
    s_ar_ready = ar_rdy_all[ar_sel] && ar_allow;
    s_w_ready  = !wf_empty && w_rdy_all[w_port];
    {err_aw_valid, m_aw_valid} = NP1'(s_aw_valid && aw_allow) << aw_sel;
    {err_ar_valid, m_ar_valid} = NP1'(s_ar_valid && ar_allow) << ar_sel;
    {err_w_valid, m_w_valid}   = NP1'(s_w_valid && !wf_empty) << w_port;
    // responses come only from the locked port, and only while something is outstanding
    {err_b_ready, m_b_ready}   = NP1'(s_b_ready && wr_cnt_q != '0) << wr_lock_q;
    {err_r_ready, m_r_ready}   = NP1'(s_r_ready && rd_cnt_q != '0) << rd_lock_q;
    s_b_valid  = (wr_cnt_q != '0) && b_vld_all[wr_lock_q];
    s_b_id     = b_id_all[wr_lock_q];
    s_b_resp   = b_resp_all[wr_lock_q];
    s_r_valid  = (rd_cnt_q != '0) && r_vld_all[rd_lock_q];
    s_r_id     = r_id_all[rd_lock_q];
    s_r_data   = r_data_all[rd_lock_q];
    s_r_resp   = r_resp_all[rd_lock_q];
    s_r_last   = r_last_all[rd_lock_q];
  end

  always_comb begin
    aw_hs     = s_aw_valid && s_aw_ready;
    ar_hs     = s_ar_valid && s_ar_ready;
    b_hs      = s_b_valid && s_b_ready;
    r_done    = s_r_valid && s_r_ready && s_r_last;
    w_pop     = s_w_valid && s_w_ready && s_w_last;
    wr_cnt_d  = wr_cnt_q + CW'(aw_hs) - CW'(b_hs);
    rd_cnt_d  = rd_cnt_q + CW'(ar_hs) - CW'(r_done);
    wr_lock_d = (aw_hs && wr_cnt_q == '0) ? aw_sel : wr_lock_q;
    rd_lock_d = (ar_hs && rd_cnt_q == '0) ? ar_sel : rd_lock_q;
    wf_mem_d  = wf_mem_q;
    if (aw_hs) wf_mem_d[wf_wr_q] = aw_sel;
    wf_wr_d   = aw_hs ? nxt(wf_wr_q) : wf_wr_q;
    wf_rd_d   = w_pop ? nxt(wf_rd_q) : wf_rd_q;
    wf_cnt_d  = wf_cnt_q + CW'(aw_hs) - CW'(w_pop);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wr_lock_q <= '0;
      rd_lock_q <= '0;
      wf_mem_q  <= '0;
      wf_wr_q   <= '0;
      wf_rd_q   <= '0;
      wf_cnt_q  <= '0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_lock_q <= wr_lock_d;
      rd_lock_q <= rd_lock_d;
      wf_mem_q  <= wf_mem_d;
      wf_wr_q   <= wf_wr_d;
      wf_rd_q   <= wf_rd_d;
      wf_cnt_q  <= wf_cnt_d;
    end
  end

  axi_demux_err_resp #(.ID_W(ID_W), .DATA_W(DATA_W)) u_err (
    .aclk     (aclk),
    .areset   (areset),
    .aw_id    (s_aw_id),
    .aw_valid (err_aw_valid),
    .aw_ready (err_aw_ready),
    .w_last   (s_w_last),
    .w_valid  (err_w_valid),
    .w_ready  (err_w_ready),
    .b_id     (err_b_id),
    .b_resp   (err_b_resp),
    .b_valid  (err_b_valid),
    .b_ready  (err_b_ready),
    .ar_id    (s_ar_id),
    .ar_len   (s_ar_len),
    .ar_valid (err_ar_valid),
    .ar_ready (err_ar_ready),
    .r_id     (err_r_id),
    .r_data   (err_r_data),
    .r_resp   (err_r_resp),
    .r_last   (err_r_last),
    .r_valid  (err_r_valid),
    .r_ready  (err_r_ready)
  );
endmodule

// File: tb/tb_axi_addr_demux.sv
// tb_axi_addr_demux: directed checks of routing, ordering locks, W-route FIFO and the DECERR responder
module tb_axi_addr_demux;
  import axi_demux_pkg::*;
  localparam int NP = 8;
  localparam int IDW = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam rule_t [1:0] TB_RULES = '{
    '{base: 64'h1FE8_0000, mask: 64'hFFFF_0000, port: 4'd5},
    '{base: 64'h0000_0000, mask: 64'hF800_0000, port: 4'd1}};

  logic aclk = 0, areset = 1;
  logic [IDW-1:0] s_aw_id = '0, s_ar_id = '0, s_b_id, s_r_id, m_aw_id, m_ar_id;
  logic [AW-1:0] s_aw_addr = '0, s_ar_addr = '0, m_aw_addr, m_ar_addr;
  logic [7:0] s_aw_len = '0, s_ar_len = '0, m_aw_len, m_ar_len;
  logic [2:0] s_aw_size = 3'd2, s_ar_size = 3'd2, m_aw_size, m_ar_size;
  logic [1:0] s_aw_burst = 2'd1, s_ar_burst = 2'd1, m_aw_burst, m_ar_burst, s_b_resp, s_r_resp;
  logic s_aw_valid = 0, s_aw_ready, s_w_last = 0, s_w_valid = 0, s_w_ready;
  logic s_b_valid, s_b_ready = 0, s_ar_valid = 0, s_ar_ready, s_r_last, s_r_valid, s_r_ready = 0;
  logic [DW-1:0] s_w_data = '0, s_r_data, m_w_data;
  logic [DW/8-1:0] s_w_strb = '1, m_w_strb;
  logic m_w_last;
  logic [NP-1:0] m_aw_valid, m_aw_ready = '0, m_w_valid, m_w_ready = '0;
  logic [NP-1:0] m_b_valid = '0, m_b_ready, m_ar_valid, m_ar_ready = '0;
  logic [NP-1:0] m_r_last = '0, m_r_valid = '0, m_r_ready;
  logic [NP-1:0][IDW-1:0] m_b_id = '0, m_r_id = '0;
  logic [NP-1:0][1:0] m_b_resp = '0, m_r_resp = '0;
  logic [NP-1:0][DW-1:0] m_r_data = '0;
  int n_chk = 0, n_fail = 0;

  axi_addr_demux #(.NUM_PORTS(NP), .NUM_RULES(2), .ID_W(IDW), .ADDR_W(AW), .DATA_W(DW),
                   .MAX_TRANS(2), .RULES(TB_RULES)) dut (
    .aclk(aclk), .areset(areset),
    .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len), .s_aw_size(s_aw_size),
    .s_aw_burst(s_aw_burst), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
    .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last), .s_w_valid(s_w_valid),
    .s_w_ready(s_w_ready),
    .s_b_id(s_b_id), .s_b_resp(s_b_resp), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
    .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
    .s_ar_burst(s_ar_burst), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_r_id(s_r_id), .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .m_aw_id(m_aw_id), .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len), .m_aw_size(m_aw_size),
    .m_aw_burst(m_aw_burst), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_last(m_w_last), .m_w_valid(m_w_valid),
    .m_w_ready(m_w_ready),
    .m_b_id(m_b_id), .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
    .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
    .m_ar_burst(m_ar_burst), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_id(m_r_id), .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready)
  );

  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    #1;
    chk("rst_r_valid", s_r_valid, 0);
    chk("rst_b_valid", s_b_valid, 0);
    chk("rst_w_ready", s_w_ready, 0);
    step();
    areset = 0;
    #1;
    chk("rst_wr_cnt", dut.wr_cnt_q, 0);
    chk("rst_aw_valid", m_aw_valid, 0);
    // read to port 1, len 3
    s_ar_addr = 32'h0000_1000; s_ar_len = 8'd3; s_ar_id = 4'd5; s_ar_valid = 1;
    #1;
    chk("ar_route", m_ar_valid, 8'h02);
    chk("ar_len_fwd", m_ar_len, 3);
    chk("ar_ready_wait", s_ar_ready, 0);
    m_ar_ready[1] = 1;
    #1;
    chk("ar_ready", s_ar_ready, 1);
    step();
    s_ar_valid = 0; m_ar_ready[1] = 0;
    m_r_valid[1] = 1; m_r_id[1] = 4'd5; s_r_ready = 1;
    m_r_valid[3] = 1; m_r_data[3] = 32'hBAD0_BAD0;
    for (int i = 0; i < 4; i++) begin
      m_r_data[1] = 32'hD0 + i; m_r_last[1] = (i == 3);
      #1;
      chk("r_data", s_r_data, 32'hD0 + i);
      chk("r_last", s_r_last, (i == 3));
      chk("r_ready_route", m_r_ready, 8'h02);
      step();
    end
    m_r_valid = '0; m_r_last = '0; s_r_ready = 0;
    #1;
    chk("rd_cnt_zero", dut.rd_cnt_q, 0);
    // unmapped read, len 1
    s_ar_addr = 32'h1234_0000; s_ar_len = 8'd1; s_ar_id = 4'd9; s_ar_valid = 1;
    #1;
    chk("err_ar_ready", s_ar_ready, 1);
    chk("err_ar_no_route", m_ar_valid, 0);
    step();
    s_ar_valid = 0; s_r_ready = 1;
    #1;
    chk("err_r1_valid", s_r_valid, 1);
    chk("err_r1_data", s_r_data, 0);
    chk("err_r1_resp", s_r_resp, 2'b11);
    chk("err_r1_id", s_r_id, 9);
    chk("err_r1_last", s_r_last, 0);
    step();
    #1;
    chk("err_r2_valid", s_r_valid, 1);
    chk("err_r2_last", s_r_last, 1);
    step();
    s_r_ready = 0;
    #1;
    chk("err_r_done", s_r_valid, 0);
    chk("err_rd_cnt", dut.rd_cnt_q, 0);
    // W ahead of AW, 4-beat burst to port 1
    s_w_valid = 1; s_w_data = 32'hA0; s_w_last = 0; m_w_ready[1] = 1;
    #1;
    chk("w_early_valid", m_w_valid, 0);
    chk("w_early_ready", s_w_ready, 0);
    s_aw_addr = 32'h0000_0100; s_aw_id = 4'd3; s_aw_len = 8'd3; s_aw_valid = 1; m_aw_ready[1] = 1;
    #1;
    chk("aw_route", m_aw_valid, 8'h02);
    chk("aw_ready", s_aw_ready, 1);
    chk("w_hs_cycle", m_w_valid, 0);
    step();
    s_aw_valid = 0;
    for (int i = 0; i < 4; i++) begin
      s_w_data = 32'hA0 + i; s_w_last = (i == 3);
      #1;
      chk("w_route", m_w_valid, 8'h02);
      chk("w_data", m_w_data, 32'hA0 + i);
      step();
    end
    s_w_valid = 0; s_w_last = 0;
    #1;
    chk("wf_popped", dut.wf_cnt_q, 0);
    chk("w_ready_empty", s_w_ready, 0);
    // port 5 AW must wait for port 1's B
    s_aw_addr = 32'h1FE8_0040; s_aw_id = 4'd6; s_aw_len = 8'd0; s_aw_valid = 1; m_aw_ready[5] = 1;
    #1;
    chk("lock_aw_ready", s_aw_ready, 0);
    chk("lock_aw_valid", m_aw_valid, 0);
    step();
    m_b_valid[1] = 1; m_b_id[1] = 4'd3; s_b_ready = 1;
    #1;
    chk("b_valid", s_b_valid, 1);
    chk("b_id", s_b_id, 3);
    chk("b_ready_route", m_b_ready, 8'h02);
    chk("lock_aw_hold", s_aw_ready, 0);
    step();
    m_b_valid[1] = 0; s_b_ready = 0;
    #1;
    chk("p5_aw_ready", s_aw_ready, 1);
    chk("p5_aw_route", m_aw_valid, 8'h20);
    step();
    s_aw_valid = 0; s_w_valid = 1; s_w_last = 1; m_w_ready[5] = 1;
    #1;
    chk("p5_w_route", m_w_valid, 8'h20);
    step();
    s_w_valid = 0; s_w_last = 0; m_b_valid[5] = 1; m_b_id[5] = 4'd6; s_b_ready = 1;
    #1;
    chk("p5_b_id", s_b_id, 6);
    step();
    m_b_valid[5] = 0; s_b_ready = 0;
    // three AWs to port 1 with MAX_TRANS=2
    s_aw_addr = 32'h0000_0200; s_aw_id = 4'd1; s_aw_valid = 1;
    #1;
    chk("mt_aw1", s_aw_ready, 1);
    step();
    #1;
    chk("mt_aw2", s_aw_ready, 1);
    step();
    #1;
    chk("mt_aw3_stall", s_aw_ready, 0);
    chk("mt_cnt2", dut.wr_cnt_q, 2);
    s_w_valid = 1; s_w_last = 1;
    step();
    step();
    s_w_valid = 0;
    #1;
    chk("mt_wf_empty", dut.wf_cnt_q, 0);
    m_b_valid[1] = 1; s_b_ready = 1;
    #1;
    chk("mt_stall_b", s_aw_ready, 0);
    step();
    #1;
    chk("mt_aw3_go", s_aw_ready, 1);
    chk("mt_b2_valid", s_b_valid, 1);
    step();
    s_aw_valid = 0; m_b_valid[1] = 0; s_b_ready = 0;
    #1;
    chk("mt_cnt_same", dut.wr_cnt_q, 1);
    chk("mt_wf1", dut.wf_cnt_q, 1);
    s_w_valid = 1;
    step();
    s_w_valid = 0; m_b_valid[1] = 1; s_b_ready = 1;
    step();
    m_b_valid[1] = 0; s_b_ready = 0;
    #1;
    chk("mt_cnt0", dut.wr_cnt_q, 0);
    // unmapped write
    s_aw_addr = 32'h1234_0000; s_aw_id = 4'd7; s_aw_len = 8'd1; s_aw_valid = 1;
    #1;
    chk("ew_aw_ready", s_aw_ready, 1);
    chk("ew_aw_no_route", m_aw_valid, 0);
    step();
    #1;
    chk("ew_busy", s_aw_ready, 0);
    s_aw_valid = 0; s_w_valid = 1; s_w_last = 0;
    #1;
    chk("ew_w_ready", s_w_ready, 1);
    chk("ew_w_no_route", m_w_valid, 0);
    step();
    s_w_last = 1;
    step();
    s_w_valid = 0; s_w_last = 0;
    #1;
    chk("ew_b_valid", s_b_valid, 1);
    chk("ew_b_resp", s_b_resp, 2'b11);
    chk("ew_b_id", s_b_id, 7);
    step();
    chk("ew_b_hold", s_b_valid, 1);
    s_b_ready = 1;
    step();
    s_b_ready = 0;
    #1;
    chk("ew_b_done", s_b_valid, 0);
    chk("ew_cnt0", dut.wr_cnt_q, 0);
    // reset in the middle of an error read burst
    s_ar_addr = 32'h1234_0000; s_ar_len = 8'd3; s_ar_id = 4'd2; s_ar_valid = 1;
    step();
    s_ar_valid = 0; s_r_ready = 1;
    #1;
    chk("rr_b1", s_r_valid, 1);
    step();
    #1;
    chk("rr_b2", s_r_valid, 1);
    chk("rr_b2_last", s_r_last, 0);
    areset = 1; s_r_ready = 0;
    step();
    #1;
    chk("rr_rst_valid", s_r_valid, 0);
    chk("rr_rst_cnt", dut.rd_cnt_q, 0);
    areset = 0;
    s_ar_len = 8'd0; s_ar_id = 4'd4; s_ar_valid = 1;
    #1;
    chk("rr_ar_ready", s_ar_ready, 1);
    step();
    s_ar_valid = 0;
    #1;
    chk("rr_new_valid", s_r_valid, 1);
    chk("rr_new_last", s_r_last, 1);
    chk("rr_new_id", s_r_id, 4);
    s_r_ready = 1;
    step();
    s_r_ready = 0;
    #1;
    chk("rr_new_done", s_r_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
